// File: rtl/custom_ip_regif.sv
// custom_ip_regif: APB3 slave bridging bus accesses to the IP's reg2ip/ip2reg register ports
module custom_ip_regif #(
  parameter int NREG        = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [4:0]           paddr_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic [NREG*32-1:0]   reg2ip_data_o,
  output logic [NREG-1:0]      reg2ip_en_o,
  input  logic [NREG-1:0]      reg2ip_ack_i,
  input  logic [NREG*33-1:0]   ip2reg_data_i
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam int LW = NREG > 1 ? $clog2(NREG) : 1;
  localparam logic [31:0] NR = NREG;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;
  state_t state, state_n;
  logic [31:0] shadow [NREG];
  logic [31:0] dat [NREG];
  logic [31:0] cap_val [NREG];
  logic [NREG-1:0] fresh, tmo, en, cap_de, rd_clr, stat_clr, tmo_set;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lane, sel;
  logic err, access, is_ctrl, is_data, is_stat, ack, expire, unused_addr;
  logic [31:0] rdata, rd_word, stat_word, widx;
  assign unused_addr   = ^paddr_i[1:0];
  assign widx          = {27'd0, paddr_i[4:2]};
  assign access        = (state == IDLE) & psel_i & penable_i & ~pready_o;
  assign is_ctrl       = widx < NR;
  assign is_data       = widx >= 32'd3 && widx < 32'd3 + NR;
  assign is_stat       = widx == 32'd6;
  assign ack           = reg2ip_ack_i[lane];
  assign expire        = cnt == CW'(ACK_TIMEOUT);
  assign stat_word     = 32'(fresh) | (32'(tmo) << 8);
  assign stat_clr      = (access & pwrite_i & is_stat) ? pwdata_i[8 +: NREG] : '0;
  assign tmo_set       = (state == WAIT_ACK & ~ack & expire) ? NREG'(1) << lane : '0;
  assign pready_o      = state == RESP;
  assign pslverr_o     = pready_o & err;
  assign prdata_o      = pready_o ? rdata : '0;
  assign reg2ip_en_o   = en;
  for (genvar k = 0; k < NREG; k++) begin : g_lane
    assign reg2ip_data_o[(NREG-k)*32-1 -: 32] = shadow[k];
    assign cap_val[k] = ip2reg_data_i[(NREG-k)*33-1 -: 32];
    assign cap_de[k]  = ip2reg_data_i[(NREG-k)*33-33];
  end
  // read mux, target lane and fresh-clear mask for the word being decoded
  always_comb begin
    rd_word = '0;
    sel     = '0;
    rd_clr  = '0;
    for (int k = 0; k < NREG; k++) begin
      if (widx == k) begin
        rd_word = shadow[k];
        sel     = LW'(k);
      end
      if (widx == 3 + k) begin
        rd_word   = dat[k];
        rd_clr[k] = access & ~pwrite_i;
      end
    end
    if (is_stat) rd_word = stat_word;
  end
  // next state: CTRL writes wait for the IP, everything else answers after one wait state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = access ? ((is_ctrl & pwrite_i) ? WAIT_ACK : RESP) : IDLE;
      WAIT_ACK: state_n = (ack | expire) ? RESP : WAIT_ACK;
      default:  state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  // shadows, captures, flags, ack counter and the latched response
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      en    <= '0;
      fresh <= '0;
      tmo   <= '0;
      cnt   <= '0;
      lane  <= '0;
      err   <= 1'b0;
      rdata <= '0;
      for (int k = 0; k < NREG; k++) begin
        shadow[k] <= '0;
        dat[k]    <= '0;
      end
    end else begin
      en    <= '0;
      fresh <= (fresh & ~rd_clr) | cap_de;
      tmo   <= (tmo & ~stat_clr) | tmo_set;
      for (int k = 0; k < NREG; k++)
        if (cap_de[k]) dat[k] <= cap_val[k];
      if (access) begin
        rdata <= pwrite_i ? '0 : rd_word;
        err   <= ~(is_ctrl | is_data | is_stat);
        if (is_ctrl & pwrite_i) begin
          shadow[sel] <= pwdata_i;
          en          <= NREG'(1) << sel;
          lane        <= sel;
          cnt         <= '0;
        end
      end
      if (state == WAIT_ACK & ~ack) begin
        if (expire) err <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_custom_ip_regif.sv
// tb_custom_ip_regif: randomized scoreboard bench for the APB register front-end
module tb_custom_ip_regif;
  localparam int NREG = 3;
  localparam int TO   = 15;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [NREG*32-1:0] r2i_data;
  logic [NREG-1:0] r2i_en;
  logic [NREG-1:0] r2i_ack = '0;
  logic [NREG*33-1:0] i2r = '0;
  always #5 clk = ~clk;
  custom_ip_regif #(.NREG(NREG), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .reg2ip_data_o(r2i_data), .reg2ip_en_o(r2i_en), .reg2ip_ack_i(r2i_ack), .ip2reg_data_i(i2r)
  );
  typedef struct {logic [31:0] d; logic e; int c;} exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] m_sh [NREG];
  logic [31:0] m_dat [NREG];
  logic [NREG-1:0] m_fresh, m_tmo, clr_req, en_mask;
  int en_cyc = -1, ack_delay = -1, cur_lane = 0, cap_cyc = -1, cap_lane = 0;
  bit noise_on = 0, cap_auto = 0;
  logic [31:0] cap_val = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < NREG; k++) begin
      m_sh[k]  = '0;
      m_dat[k] = '0;
    end
    m_fresh = '0;
    m_tmo   = '0;
    clr_req = '0;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_prdata"}, prdata, 0);
    chk({tag, "_pready"}, 32'(pready), 0);
    chk({tag, "_pslverr"}, 32'(pslverr), 0);
    chk({tag, "_en"}, 32'(r2i_en), 0);
    for (int k = 0; k < NREG; k++) chk({tag, "_data_o"}, r2i_data[(NREG-k)*32-1 -: 32], 0);
  endtask
  // one APB transfer; the expected response comes from the register model
  task automatic apb(input bit wr, input logic [4:0] addr, input logic [31:0] wd, input int d,
                     input bit cap, input logic [31:0] cv);
    int w, a, n;
    exp_t e;
    bit got;
    w = int'(addr[4:2]);
    cur_lane = (w < NREG) ? w : 0;
    ack_delay = d;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    if (cap) begin
      cap_cyc = cyc + 1; cap_lane = 0; cap_val = cv;
    end
    @(posedge clk); #1;
    penable = 1'b1;
    a = cyc;
    e.d = '0; e.e = 1'b0; e.c = a + 1;
    if (w < NREG) begin
      if (wr) begin
        e.e = (d < 0 || d >= TO);
        e.c = e.e ? a + TO + 2 : a + 3 + d;
        en_cyc = a + 1;
        en_mask = NREG'(1 << w);
      end else e.d = m_sh[w];
    end else if (w < 2*NREG) begin
      if (!wr) begin
        e.d = m_dat[w-NREG];
        clr_req[w-NREG] = 1'b1;
      end
    end else if (w == 2*NREG) begin
      if (!wr) e.d = 32'(m_fresh) | (32'(m_tmo) << 8);
    end else e.e = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (wr && w < NREG) m_sh[w] = wd;
    if (wr && w == 2*NREG) m_tmo = m_tmo & ~wd[8 +: NREG];
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = pready;
      n++;
    end
    chk("pready_seen", 32'(got), 1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (wr && w < NREG && e.e) m_tmo[w] = 1'b1;
  endtask
  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // IP acknowledge model: ack the strobed lane after ack_delay cycles (never if negative)
  initial begin
    logic [NREG-1:0] pend, noise;
    int cd;
    pend = '0; cd = -1;
    forever begin
      @(negedge clk);
      if (r2i_en != 0) begin
        pend = r2i_en; cd = ack_delay;
      end
      @(posedge clk); #1;
      noise = noise_on ? (NREG'($urandom) & ~NREG'(1 << cur_lane)) : '0;
      if (pend != 0 && cd == 0) begin
        r2i_ack = pend | noise; pend = '0;
      end else begin
        r2i_ack = noise;
        if (cd > 0) cd--;
      end
    end
  end
  // ip2reg stimulus and capture model
  initial begin
    logic [32:0] f;
    bit de;
    forever begin
      @(posedge clk);
      if (rst_ni)
        for (int k = 0; k < NREG; k++) begin
          f = i2r[(NREG-k)*33-1 -: 33];
          if (f[0]) begin
            m_dat[k] = f[32:1]; m_fresh[k] = 1'b1;
          end else if (clr_req[k]) m_fresh[k] = 1'b0;
        end
      clr_req = '0;
      #2;
      for (int k = 0; k < NREG; k++) begin
        de = cap_auto ? ($urandom_range(0, 5) == 0) : (cyc == cap_cyc && k == cap_lane);
        i2r[(NREG-k)*33-1 -: 33] = {(de && !cap_auto) ? cap_val : $urandom, de};
      end
    end
  end
  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && pready) begin
        if (sbq.size() == 0) chk("unexpected_pready", 32'(pready), 0);
        else begin
          e = sbq.pop_front();
          chk("prdata", prdata, e.d);
          chk("pslverr", 32'(pslverr), 32'(e.e));
          chk("resp_cycle", cyc, e.c);
        end
      end
    end
  end
  // strobe and shadow output monitor
  initial forever begin
    @(negedge clk);
    if (rst_ni) begin
      chk("reg2ip_en", 32'(r2i_en), 32'((cyc == en_cyc) ? en_mask : '0));
      for (int k = 0; k < NREG; k++) chk("reg2ip_data", r2i_data[(NREG-k)*32-1 -: 32], m_sh[k]);
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, d, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    apb(1, 5'h04, 32'hDEADBEEF, 0, 0, 0);
    apb(0, 5'h04, 0, 0, 0, 0);
    apb(1, 5'h08, 32'h00001234, -1, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    apb(1, 5'h18, 32'h00000400, 0, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    @(posedge clk); #1;
    cap_cyc = cyc + 1; cap_lane = 0; cap_val = 32'h00002468;
    repeat (3) @(posedge clk);
    apb(0, 5'h18, 0, 0, 0, 0);
    apb(0, 5'h0C, 0, 0, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    apb(0, 5'h10, 0, 0, 0, 0);
    apb(0, 5'h14, 0, 0, 0, 0);
    apb(0, 5'h0C, 0, 0, 1, 32'h0000369C);
    apb(0, 5'h18, 0, 0, 0, 0);
    apb(0, 5'h0C, 0, 0, 0, 0);
    apb(0, 5'h1C, 0, 0, 0, 0);
    apb(1, 5'h1C, 32'hFFFFFFFF, 0, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    apb(0, 5'h00, 0, 0, 0, 0);
    apb(1, 5'h00, 32'h11111111, TO - 1, 0, 0);
    apb(1, 5'h00, 32'h22222222, TO, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    cur_lane = 0; ack_delay = -1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1; en_cyc = cyc + 1; en_mask = NREG'(1);
    @(posedge clk); #1;
    m_sh[0] = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    check_idle_outputs("abort");
    model_reset();
    en_cyc = -1; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (6) @(posedge clk);
    apb(1, 5'h00, 32'h0BADF00D, 1, 0, 0);
    apb(0, 5'h00, 0, 0, 0, 0);
    apb(0, 5'h18, 0, 0, 0, 0);
    cap_auto = 1; noise_on = 1;
    repeat (200) begin
      w = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      d = (r < 6) ? $urandom_range(0, 3) : (r == 6) ? TO - 1 : (r == 7) ? TO : (r == 8) ? -1 : $urandom_range(0, TO - 1);
      apb(1'($urandom), {3'(w), 2'($urandom)}, $urandom, d, 0, 0);
    end
    cap_auto = 0; noise_on = 0;
    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
